// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the roulette display path (active-low, bit 6 = a .. bit 0 = g).
// Also holds the reader's state encoding.
package seg7_pkg;

   localparam logic [6:0] SEG_DIG0  = 7'b0000001;
   localparam logic [6:0] SEG_DIG1  = 7'b1001111;
   localparam logic [6:0] SEG_DIG2  = 7'b0010010;
   localparam logic [6:0] SEG_DIG3  = 7'b0000110;
   localparam logic [6:0] SEG_DIG4  = 7'b1001100;
   localparam logic [6:0] SEG_DIG5  = 7'b0100100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-low segment pattern to roulette value 0-5.
// Reports a legal digit and the blank pattern separately.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       is_digit,
   output logic       is_blank,
   output logic [2:0] value
);

   always_comb begin
      is_digit = 1'b1;
      is_blank = 1'b0;
      value    = 3'd0;
      case (pattern)
         SEG_DIG0:  value = 3'd0;
         SEG_DIG1:  value = 3'd1;
         SEG_DIG2:  value = 3'd2;
         SEG_DIG3:  value = 3'd3;
         SEG_DIG4:  value = 3'd4;
         SEG_DIG5:  value = 3'd5;
         SEG_BLANK: begin
            is_digit = 1'b0;
            is_blank = 1'b1;
         end
         default:   is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_reader.sv
// Debounced receive-side 7-segment decoder: accepts a pattern after STABLE_CYCLES identical samples.
// Optional saturating invalid-pattern counter under SEG7_READER_ERRCNT_EN.
module seg7_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk_main,
   input  logic       reset,
   input  logic [6:0] seg_in,
   output logic [2:0] data,
   output logic       data_valid,
   output logic       invalid,
   output logic       locked,
   output logic       blank,
`ifdef SEG7_READER_ERRCNT_EN
   output logic [7:0] err_count,
`endif
   output state_t     state_dbg
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

   state_t        state;
   logic [6:0]    seg_q;
   logic [6:0]    cand;
   logic [6:0]    acc;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          differ;
   logic          acc_req;

   logic          dec_digit;
   logic          dec_blank;
   logic [2:0]    dec_value;

   assign differ    = (seg_q != cand);
   assign cnt_inc   = cnt + CNT_ONE;
   assign state_dbg = state;

   seg7_pattern_decode u_decode (
      .pattern  (cand),
      .is_digit (dec_digit),
      .is_blank (dec_blank),
      .value    (dec_value)
   );

   // acc_req marks the acceptance edge; outputs follow one edge later using cand,
   // which still holds the accepted pattern at that point.
   always_ff @(posedge clk_main) begin
      if (reset) begin
         state   <= IDLE;
         seg_q   <= SEG_BLANK;
         cand    <= SEG_BLANK;
         cnt     <= '0;
         acc_req <= 1'b0;
      end else begin
         seg_q   <= seg_in;
         acc_req <= 1'b0;
         case (state)
            IDLE: begin
               cand <= seg_q;
               cnt  <= CNT_ONE;
               if (CNT_ONE >= CNT_MAX) begin
                  acc_req <= 1'b1;
                  state   <= HOLD;
               end else begin
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               if (differ) begin
                  cand <= seg_q;
                  cnt  <= CNT_ONE;
                  if (CNT_ONE >= CNT_MAX) begin
                     acc_req <= 1'b1;
                     state   <= HOLD;
                  end
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc >= CNT_MAX) begin
                     acc_req <= 1'b1;
                     state   <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (differ) begin
                  cand <= seg_q;
                  cnt  <= CNT_ONE;
                  if (CNT_ONE >= CNT_MAX) begin
                     acc_req <= 1'b1;
                  end else begin
                     state   <= SETTLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_main) begin
      if (reset) begin
         acc        <= SEG_BLANK;
         data       <= 3'd0;
         data_valid <= 1'b0;
         invalid    <= 1'b0;
         locked     <= 1'b0;
         blank      <= 1'b1;
`ifdef SEG7_READER_ERRCNT_EN
         err_count  <= 8'd0;
`endif
      end else begin
         data_valid <= 1'b0;
         invalid    <= 1'b0;
         // Re-accepting the current pattern (glitch recovery) must stay silent.
         if (acc_req && (cand != acc)) begin
            acc <= cand;
            if (dec_digit) begin
               data       <= dec_value;
               data_valid <= 1'b1;
               locked     <= 1'b1;
               blank      <= 1'b0;
            end else if (dec_blank) begin
               locked     <= 1'b0;
               blank      <= 1'b1;
            end else begin
               invalid    <= 1'b1;
               locked     <= 1'b0;
               blank      <= 1'b0;
`ifdef SEG7_READER_ERRCNT_EN
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader (STABLE_CYCLES = 4); err_count checks only with SEG7_READER_ERRCNT_EN.
// Pulse timing is measured in edges from the first edge that samples a new seg_in value.
module tb_seg7_reader;
   import seg7_pkg::*;

   localparam int S = 4;

   logic       clk_main;
   logic       reset;
   logic [6:0] seg_in;
   logic [2:0] data;
   logic       data_valid;
   logic       invalid;
   logic       locked;
   logic       blank;
`ifdef SEG7_READER_ERRCNT_EN
   logic [7:0] err_count;
`endif
   state_t     state_dbg;

   int tests_run = 0;
   int tests_failed = 0;
   int dv_cnt, inv_cnt, dv_at, inv_at;
   logic [2:0] exp_q[$];

   seg7_reader #(.STABLE_CYCLES(S)) dut (
      .clk_main   (clk_main),
      .reset      (reset),
      .seg_in     (seg_in),
      .data       (data),
      .data_valid (data_valid),
      .invalid    (invalid),
      .locked     (locked),
      .blank      (blank),
`ifdef SEG7_READER_ERRCNT_EN
      .err_count  (err_count),
`endif
      .state_dbg  (state_dbg)
   );

   // clock / watchdog
   initial begin
      clk_main = 1'b0;
      forever #5 clk_main = ~clk_main;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_seg(input logic [6:0] p);
      seg_in  = p;
      dv_cnt  = 0;
      inv_cnt = 0;
      dv_at   = -1;
      inv_at  = -1;
   endtask

   // Advance n edges; k = 0 is the edge that first samples the value set by set_seg.
   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_main);
         #1;
         if (data_valid) begin
            dv_cnt++;
            dv_at = k;
            check("dv_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("dv_data", 32'(data), 32'(exp_q.pop_front()));
         end
         if (invalid) begin
            inv_cnt++;
            inv_at = k;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},   32'(data),       32'd0);
      check({tag, "_dv"},     32'(data_valid), 32'd0);
      check({tag, "_inv"},    32'(invalid),    32'd0);
      check({tag, "_locked"}, 32'(locked),     32'd0);
      check({tag, "_blank"},  32'(blank),      32'd1);
`ifdef SEG7_READER_ERRCNT_EN
      check({tag, "_errcnt"}, 32'(err_count),  32'd0);
`endif
   endtask

   initial begin
      reset = 1'b1;
      set_seg(SEG_BLANK);
      run(3);
      check_reset_outputs("reset");
      reset = 1'b0;
      run(8);
      check("idle_blank", 32'(blank), 32'd1);
      check("idle_pulses", 32'(dv_cnt + inv_cnt), 32'd0);

      // digit 0 from blank: one pulse at edge S+1
      set_seg(SEG_DIG0);
      exp_q.push_back(3'd0);
      run(12);
      check("d0_dv_cnt", 32'(dv_cnt), 32'd1);
      check("d0_dv_at",  32'(dv_at),  32'(S + 1));
      check("d0_data",   32'(data),   32'd0);
      check("d0_locked", 32'(locked), 32'd1);
      check("d0_blank",  32'(blank),  32'd0);

      // lock on 3, then a 3-sample glitch to 1 and back
      set_seg(SEG_DIG3);
      exp_q.push_back(3'd3);
      run(12);
      check("d3_dv_cnt", 32'(dv_cnt), 32'd1);
      check("d3_data",   32'(data),   32'd3);
      set_seg(SEG_DIG1);
      run(S - 1);
      set_seg(SEG_DIG3);
      run(12);
      check("glitch_dv",     32'(dv_cnt),  32'd0);
      check("glitch_inv",    32'(inv_cnt), 32'd0);
      check("glitch_data",   32'(data),    32'd3);
      check("glitch_locked", 32'(locked),  32'd1);

      // 3 -> 5, held: exactly one pulse at S+1
      set_seg(SEG_DIG5);
      exp_q.push_back(3'd5);
      run(20);
      check("d5_dv_cnt", 32'(dv_cnt), 32'd1);
      check("d5_dv_at",  32'(dv_at),  32'(S + 1));
      check("d5_data",   32'(data),   32'd5);

      // "8" is illegal
      set_seg(7'b0000000);
      run(12);
      check("ill_inv_cnt", 32'(inv_cnt), 32'd1);
      check("ill_inv_at",  32'(inv_at),  32'(S + 1));
      check("ill_dv_cnt",  32'(dv_cnt),  32'd0);
      check("ill_locked",  32'(locked),  32'd0);
      check("ill_blank",   32'(blank),   32'd0);
      check("ill_data",    32'(data),    32'd5);
`ifdef SEG7_READER_ERRCNT_EN
      check("ill_errcnt", 32'(err_count), 32'd1);
      for (int i = 0; i < 300; i++) begin
         set_seg((i % 2 == 0) ? 7'b1111110 : 7'b0000000);
         run(S + 3);
      end
      check("errcnt_sat", 32'(err_count), 32'd255);
`endif

      // blank display, then 4
      set_seg(SEG_BLANK);
      run(12);
      check("blk_blank",  32'(blank),            32'd1);
      check("blk_locked", 32'(locked),           32'd0);
      check("blk_pulses", 32'(dv_cnt + inv_cnt), 32'd0);
      check("blk_data",   32'(data),             32'd5);
      set_seg(SEG_DIG4);
      exp_q.push_back(3'd4);
      run(12);
      check("d4_dv_cnt", 32'(dv_cnt), 32'd1);
      check("d4_data",   32'(data),   32'd4);
      check("d4_blank",  32'(blank),  32'd0);
      check("d4_locked", 32'(locked), 32'd1);

      // reset two edges into SETTLE for 2
      set_seg(SEG_DIG2);
      run(3);
      check("pre_rst_dv", 32'(dv_cnt), 32'd0);
      reset = 1'b1;
      run(1);
      check_reset_outputs("midrst");
      check("midrst_state", 32'(state_dbg), 32'(IDLE));
      reset = 1'b0;
      exp_q.push_back(3'd2);
      set_seg(SEG_DIG2);
      run(12);
      check("d2_dv_cnt", 32'(dv_cnt), 32'd1);
      check("d2_dv_at",  32'(dv_at),  32'(S + 1));
      check("d2_data",   32'(data),   32'd2);
      check("d2_locked", 32'(locked), 32'd1);

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
